// File: rtl/input_port_param_pkg.sv
// Shared network types and constants for the router input port: flit format,
// port encoding, flow-control mode encodings and per-VC packet tracker states.
package input_port_param_pkg;

  localparam int PORT_NUM         = 5;
  localparam int VC_PER_PORT      = 4;
  localparam int QUEUE_LEN_PER_VC = 4;
  localparam int VC_ID_W          = 3;
  localparam int PAYLOAD_W        = 16;

  localparam int FC_ON_OFF = 0;
  localparam int FC_CREDIT = 1;

  typedef logic [2:0] port_t;

  typedef enum logic [1:0] {
    HEADER = 2'd0,
    BODY   = 2'd1,
    TAIL   = 2'd2,
    HT     = 2'd3
  } flit_type_e;

  typedef struct packed {
    flit_type_e           flit_type;
    logic [VC_ID_W-1:0]   vc_id;
    port_t                next_hop_port;
  } header_t;

  typedef struct packed {
    header_t              header;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef enum logic {
    TRK_IDLE = 1'b0,
    TRK_OPEN = 1'b1
  } trk_state_e;

  function automatic logic [PORT_NUM-1:0] port_onehot(input port_t p);
    return PORT_NUM'(1) << p;
  endfunction

endpackage

// File: rtl/input_port_param_vc_buffer.sv
// One virtual channel: show-ahead flit FIFO, route queue of next-hop ports,
// occupancy counter, packet-sequence tracker and flow-control generation.
module vc_buffer
  import input_port_param_pkg::*;
#(
  parameter int DEPTH         = QUEUE_LEN_PER_VC,
  parameter int FC_MODE       = FC_ON_OFF,
  parameter int ON_OFF_MARGIN = 1,
  localparam int PTR_W        = $clog2(DEPTH),
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  flit_t               flit_in,
  input  logic                grant,
  input  logic                err_clear,
  output flit_t               flit_out,
  output logic [PORT_NUM-1:0] dest_port,
  output logic                empty,
  output logic [CNT_W-1:0]    occupancy,
  output logic                flow_ctrl,
  output logic                proto_err
);

  flit_t            r_mem   [DEPTH];
  port_t            r_route [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, r_rt_wr_ptr, r_rt_rd_ptr;
  logic [CNT_W-1:0] r_count, r_rt_count;
  trk_state_e       r_state;
  logic             r_err;
  logic             r_credit;

  flit_type_e w_in_type, w_out_type;
  logic       w_full, w_deq, w_enq, w_overflow, w_is_head, w_seq_err;
  logic       w_rt_pop, w_rt_push, w_onoff;

  assign w_in_type  = flit_in.header.flit_type;
  assign w_out_type = r_mem[r_rd_ptr].header.flit_type;
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign empty      = (r_count == '0);
  assign w_deq      = grant & ~empty;
  // A full VC still accepts a write when the head leaves in the same cycle.
  assign w_enq      = wr_en & (~w_full | w_deq);
  assign w_overflow = wr_en & w_full & ~w_deq;
  assign w_is_head  = (w_in_type == HEADER) || (w_in_type == HT);
  assign w_seq_err  = w_enq & ((r_state == TRK_IDLE) ?
                               ((w_in_type == BODY) || (w_in_type == TAIL)) : w_is_head);
  assign w_rt_pop   = w_deq & ((w_out_type == TAIL) || (w_out_type == HT)) & (r_rt_count != '0);
  // Illegal sequences can push more routes than tails pop; never overrun the queue.
  assign w_rt_push  = w_enq & w_is_head & ((r_rt_count != CNT_W'(DEPTH)) | w_rt_pop);

  // NOTE: storage arrays are not reset; pointers and counts alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_enq)     r_mem[r_wr_ptr]      <= flit_in;
    if (w_rt_push) r_route[r_rt_wr_ptr] <= flit_in.header.next_hop_port;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rt_wr_ptr <= '0;
      r_rt_rd_ptr <= '0;
      r_rt_count  <= '0;
      r_state     <= TRK_IDLE;
      r_err       <= 1'b0;
      r_credit    <= 1'b0;
    end else begin
      if (w_enq)     r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
      if (w_deq)     r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
      if (w_rt_push) r_rt_wr_ptr <= r_rt_wr_ptr + PTR_W'(1);
      if (w_rt_pop)  r_rt_rd_ptr <= r_rt_rd_ptr + PTR_W'(1);
      r_count    <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
      r_rt_count <= r_rt_count + CNT_W'(w_rt_push) - CNT_W'(w_rt_pop);

      if (w_enq) begin
        case (w_in_type)
          HEADER:   r_state <= TRK_OPEN;
          HT, TAIL: r_state <= TRK_IDLE;
          default:  r_state <= r_state;
        endcase
      end

      // A new error wins over a same-cycle clear.
      if (w_overflow || w_seq_err) r_err <= 1'b1;
      else if (err_clear)          r_err <= 1'b0;

      r_credit <= w_deq;
    end
  end

  assign w_onoff   = (r_count >= CNT_W'(DEPTH - ON_OFF_MARGIN));
  assign flow_ctrl = (FC_MODE == FC_CREDIT) ? r_credit : w_onoff;
  assign flit_out  = r_mem[r_rd_ptr];
  assign dest_port = (r_rt_count == '0) ? '0 : port_onehot(r_route[r_rt_rd_ptr]);
  assign occupancy = r_count;
  assign proto_err = r_err;

endmodule

// File: rtl/input_port_param.sv
// Router input port: steers incoming flits to one of VC_NUM virtual-channel
// buffers by header.vc_id and exposes each VC's head flit, route and status.
module input_port_param
  import input_port_param_pkg::*;
#(
  parameter int VC_NUM        = VC_PER_PORT,
  parameter int DEPTH         = QUEUE_LEN_PER_VC,
  parameter int FC_MODE       = FC_ON_OFF,
  parameter int ON_OFF_MARGIN = 1,
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en_in,
  input  flit_t                            flit_in,
  output logic [VC_NUM-1:0]                flow_ctrl_out,
  output flit_t [VC_NUM-1:0]               ip_flit_out,
  output logic [VC_NUM-1:0][PORT_NUM-1:0]  ip_dest_port,
  input  logic [VC_NUM-1:0]                sa_grant,
  output logic [VC_NUM-1:0]                ip_empty,
  output logic [VC_NUM-1:0][CNT_W-1:0]     vc_occupancy,
  output logic [VC_NUM-1:0]                proto_err,
  input  logic                             err_clear
);

  // A vc_id outside 0..VC_NUM-1 matches no buffer, so the flit is dropped.
  for (genvar i = 0; i < VC_NUM; i++) begin : g_vc
    logic w_sel;
    assign w_sel = wr_en_in && (flit_in.header.vc_id == VC_ID_W'(i));

    vc_buffer #(
      .DEPTH         (DEPTH),
      .FC_MODE       (FC_MODE),
      .ON_OFF_MARGIN (ON_OFF_MARGIN)
    ) u_vc_buffer (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (w_sel),
      .flit_in   (flit_in),
      .grant     (sa_grant[i]),
      .err_clear (err_clear),
      .flit_out  (ip_flit_out[i]),
      .dest_port (ip_dest_port[i]),
      .empty     (ip_empty[i]),
      .occupancy (vc_occupancy[i]),
      .flow_ctrl (flow_ctrl_out[i]),
      .proto_err (proto_err[i])
    );
  end

endmodule

// File: tb/tb_input_port_param.sv
// Bench for input_port_param: on/off and credit instances share stimulus and are
// checked against a queue-based model, a directed vector table and random traffic.
module tb_input_port_param;
  import input_port_param_pkg::*;

  localparam int VCN = 4;
  localparam int D   = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   wr_en_in;
  flit_t                  flit_in;
  logic [VCN-1:0]         sa_grant;
  logic                   err_clear;

  logic [VCN-1:0]         fc0, fc1, emp0, emp1, err0, err1;
  flit_t [VCN-1:0]        fo0, fo1;
  logic [VCN-1:0][4:0]    dst0, dst1;
  logic [VCN-1:0][2:0]    occ0, occ1;

  input_port_param #(.VC_NUM(VCN), .DEPTH(D), .FC_MODE(0), .ON_OFF_MARGIN(1)) dut0 (
    .clk(clk), .reset(reset), .wr_en_in(wr_en_in), .flit_in(flit_in),
    .flow_ctrl_out(fc0), .ip_flit_out(fo0), .ip_dest_port(dst0), .sa_grant(sa_grant),
    .ip_empty(emp0), .vc_occupancy(occ0), .proto_err(err0), .err_clear(err_clear));

  input_port_param #(.VC_NUM(VCN), .DEPTH(D), .FC_MODE(1), .ON_OFF_MARGIN(1)) dut1 (
    .clk(clk), .reset(reset), .wr_en_in(wr_en_in), .flit_in(flit_in),
    .flow_ctrl_out(fc1), .ip_flit_out(fo1), .ip_dest_port(dst1), .sa_grant(sa_grant),
    .ip_empty(emp1), .vc_occupancy(occ1), .proto_err(err1), .err_clear(err_clear));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-VC flit queues, route queues, open-packet flags, errors, credits.
  flit_t mq [VCN][$];
  port_t rq [VCN][$];
  bit    m_open   [VCN];
  bit    m_err    [VCN];
  bit    m_credit [VCN];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic flit_t mk_flit(input flit_type_e ft, input logic [2:0] vc, input port_t p,
                                    input logic [15:0] pl);
    flit_t f;
    f.header.flit_type     = ft;
    f.header.vc_id         = vc;
    f.header.next_hop_port = p;
    f.payload              = pl;
    return f;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < VCN; v++) begin
      mq[v].delete();
      rq[v].delete();
      m_open[v]   = 1'b0;
      m_err[v]    = 1'b0;
      m_credit[v] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int v = 0; v < VCN; v++) begin
      bit         deq, hit, acc, err;
      flit_t      head;
      flit_type_e ft;
      deq = sa_grant[v] && (mq[v].size() > 0);
      hit = wr_en_in && (int'(flit_in.header.vc_id) == v);
      acc = hit && ((mq[v].size() < D) || deq);
      err = hit && !acc;
      if (deq) begin
        head = mq[v].pop_front();
        if ((head.header.flit_type == TAIL || head.header.flit_type == HT) && rq[v].size() > 0)
          void'(rq[v].pop_front());
      end
      if (acc) begin
        ft = flit_in.header.flit_type;
        if (!m_open[v] && (ft == BODY || ft == TAIL))  err = 1'b1;
        if (m_open[v] && (ft == HEADER || ft == HT))   err = 1'b1;
        if (ft == HEADER)                 m_open[v] = 1'b1;
        else if (ft == HT || ft == TAIL)  m_open[v] = 1'b0;
        mq[v].push_back(flit_in);
        if ((ft == HEADER || ft == HT) && rq[v].size() < D)
          rq[v].push_back(flit_in.header.next_hop_port);
      end
      if (err)            m_err[v] = 1'b1;
      else if (err_clear) m_err[v] = 1'b0;
      m_credit[v] = deq;
    end
  endtask

  task automatic compare_all();
    for (int v = 0; v < VCN; v++) begin
      logic [4:0] exp_dst;
      exp_dst = (rq[v].size() == 0) ? 5'd0 : (5'd1 << rq[v][0]);
      check($sformatf("occ[%0d]", v),   64'(occ0[v]), 64'(mq[v].size()));
      check($sformatf("occ_m1[%0d]", v), 64'(occ1[v]), 64'(mq[v].size()));
      check($sformatf("empty[%0d]", v), 64'(emp0[v]), 64'(mq[v].size() == 0));
      check($sformatf("err[%0d]", v),   64'(err0[v]), 64'(m_err[v]));
      check($sformatf("err_m1[%0d]", v), 64'(err1[v]), 64'(m_err[v]));
      check($sformatf("dest[%0d]", v),  64'(dst0[v]), 64'(exp_dst));
      check($sformatf("fc_onoff[%0d]", v), 64'(fc0[v]), 64'(mq[v].size() >= D - 1));
      check($sformatf("fc_credit[%0d]", v), 64'(fc1[v]), 64'(m_credit[v]));
      if (mq[v].size() > 0) begin
        check($sformatf("flit[%0d]", v),    64'(fo0[v]), 64'(mq[v][0]));
        check($sformatf("flit_m1[%0d]", v), 64'(fo1[v]), 64'(mq[v][0]));
      end
    end
  endtask

  task automatic cycle(input logic wr, input flit_t f, input logic [VCN-1:0] g, input logic clr);
    @(negedge clk);
    wr_en_in  = wr;
    flit_in   = f;
    sa_grant  = g;
    err_clear = clr;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    wr_en_in  = 1'b0;
    sa_grant  = '0;
    err_clear = 1'b0;
    model_reset();
    #1;
    check("rst_empty", 64'(emp0), 64'hF);
    check("rst_occ",   64'(occ0), 64'h0);
    check("rst_dest",  64'(dst0), 64'h0);
    check("rst_err",   64'(err0), 64'h0);
    check("rst_fc0",   64'(fc0),  64'h0);
    check("rst_fc1",   64'(fc1),  64'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic           wr;
    flit_type_e     ft;
    logic [2:0]     vc;
    port_t          port;
    logic [VCN-1:0] g;
    logic           clr;
    int             ovc;
    int             occ;
    logic           fc0;
    logic           fc1;
    logic           err;
    logic [4:0]     dest;
  } vec_t;

  vec_t vecs [23];

  initial begin
    vecs = '{
      // VC2: H,B,B,T without grants, then drain it with four grants
      '{1'b1, HEADER, 3'd2, 3'd3, 4'b0000, 1'b0, 2, 1, 1'b0, 1'b0, 1'b0, 5'b01000},
      '{1'b1, BODY,   3'd2, 3'd0, 4'b0000, 1'b0, 2, 2, 1'b0, 1'b0, 1'b0, 5'b01000},
      '{1'b1, BODY,   3'd2, 3'd0, 4'b0000, 1'b0, 2, 3, 1'b1, 1'b0, 1'b0, 5'b01000},
      '{1'b1, TAIL,   3'd2, 3'd0, 4'b0000, 1'b0, 2, 4, 1'b1, 1'b0, 1'b0, 5'b01000},
      '{1'b0, BODY,   3'd0, 3'd0, 4'b0100, 1'b0, 2, 3, 1'b1, 1'b1, 1'b0, 5'b01000},
      '{1'b0, BODY,   3'd0, 3'd0, 4'b0100, 1'b0, 2, 2, 1'b0, 1'b1, 1'b0, 5'b01000},
      '{1'b0, BODY,   3'd0, 3'd0, 4'b0100, 1'b0, 2, 1, 1'b0, 1'b1, 1'b0, 5'b01000},
      '{1'b0, BODY,   3'd0, 3'd0, 4'b0100, 1'b0, 2, 0, 1'b0, 1'b1, 1'b0, 5'b00000},
      '{1'b0, BODY,   3'd0, 3'd0, 4'b0000, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0, 5'b00000},
      // VC0: fill, write+grant while full, then overflow
      '{1'b1, HEADER, 3'd0, 3'd0, 4'b0000, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 5'b00001},
      '{1'b1, BODY,   3'd0, 3'd0, 4'b0000, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0, 5'b00001},
      '{1'b1, BODY,   3'd0, 3'd0, 4'b0000, 1'b0, 0, 3, 1'b1, 1'b0, 1'b0, 5'b00001},
      '{1'b1, BODY,   3'd0, 3'd0, 4'b0000, 1'b0, 0, 4, 1'b1, 1'b0, 1'b0, 5'b00001},
      '{1'b1, BODY,   3'd0, 3'd0, 4'b0001, 1'b0, 0, 4, 1'b1, 1'b1, 1'b0, 5'b00001},
      '{1'b1, BODY,   3'd0, 3'd0, 4'b0000, 1'b0, 0, 4, 1'b1, 1'b0, 1'b1, 5'b00001},
      // VC1: BODY while idle, clear, then TAIL while idle together with clear
      '{1'b1, BODY,   3'd1, 3'd0, 4'b0000, 1'b0, 1, 1, 1'b0, 1'b0, 1'b1, 5'b00000},
      '{1'b0, BODY,   3'd0, 3'd0, 4'b0000, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0, 5'b00000},
      '{1'b1, TAIL,   3'd1, 3'd0, 4'b0000, 1'b1, 1, 2, 1'b0, 1'b0, 1'b1, 5'b00000},
      // VC3: two HT packets to ports 1 and 4
      '{1'b1, HT,     3'd3, 3'd1, 4'b0000, 1'b0, 3, 1, 1'b0, 1'b0, 1'b0, 5'b00010},
      '{1'b1, HT,     3'd3, 3'd4, 4'b0000, 1'b0, 3, 2, 1'b0, 1'b0, 1'b0, 5'b00010},
      '{1'b0, BODY,   3'd0, 3'd0, 4'b1000, 1'b0, 3, 1, 1'b0, 1'b1, 1'b0, 5'b10000},
      '{1'b0, BODY,   3'd0, 3'd0, 4'b1000, 1'b0, 3, 0, 1'b0, 1'b1, 1'b0, 5'b00000},
      // out-of-range vc_id is dropped
      '{1'b1, HEADER, 3'd5, 3'd2, 4'b0000, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0, 5'b00000}
    };

    reset     = 1'b0;
    wr_en_in  = 1'b0;
    flit_in   = '0;
    sa_grant  = '0;
    err_clear = 1'b0;
    model_reset();
    do_reset();

    for (int i = 0; i < 23; i++) begin
      int v;
      v = vecs[i].ovc;
      cycle(vecs[i].wr, mk_flit(vecs[i].ft, vecs[i].vc, vecs[i].port, 16'(i * 17 + 3)),
            vecs[i].g, vecs[i].clr);
      check($sformatf("vec%0d_occ", i),  64'(occ0[v]), 64'(vecs[i].occ));
      check($sformatf("vec%0d_fc0", i),  64'(fc0[v]),  64'(vecs[i].fc0));
      check($sformatf("vec%0d_fc1", i),  64'(fc1[v]),  64'(vecs[i].fc1));
      check($sformatf("vec%0d_err", i),  64'(err0[v]), 64'(vecs[i].err));
      check($sformatf("vec%0d_dest", i), 64'(dst0[v]), 64'(vecs[i].dest));
    end

    // Reset in the middle of a VC2 packet, then start a fresh packet
    cycle(1'b1, mk_flit(HEADER, 3'd2, 3'd2, 16'h1111), 4'b0000, 1'b0);
    cycle(1'b1, mk_flit(BODY,   3'd2, 3'd0, 16'h2222), 4'b0100, 1'b0);
    do_reset();
    cycle(1'b0, mk_flit(BODY, 3'd0, 3'd0, 16'h0), 4'b1111, 1'b0);
    check("post_rst_credit", 64'(fc1), 64'h0);
    cycle(1'b1, mk_flit(HEADER, 3'd2, 3'd0, 16'h3333), 4'b0000, 1'b0);
    check("post_rst_hdr_err", 64'(err0[2]), 64'h0);
    check("post_rst_hdr_occ", 64'(occ0[2]), 64'h1);
    check("post_rst_hdr_dst", 64'(dst0[2]), 64'h1);

    // Random traffic against the model, with one reset partway through
    for (int n = 0; n < 3000; n++) begin
      logic [2:0]     vc;
      logic [VCN-1:0] g;
      flit_type_e     ft;
      if (n == 1500) do_reset();
      vc = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      ft = flit_type_e'($urandom_range(0, 3));
      for (int b = 0; b < VCN; b++) g[b] = ($urandom_range(0, 9) < 4);
      cycle(($urandom_range(0, 3) != 0), mk_flit(ft, vc, 3'($urandom_range(0, 4)), 16'($urandom)),
            g, ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
